// File: rtl/c1_bus_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | c1_bus_master : core-side initiator for the C1 cache bus (a1/d1/c1).       |
// | Optional macro C1_BUS_TIMEOUT_EN adds a response watchdog.  Rev 1.0        |
// +----------------------------------------------------------------------------+
module c1_bus_master #(
    parameter int ADDR_SIZE      = 5,
    parameter int DATA1_BUS_SIZE = 16,
    parameter int CTR1_BUS_SIZE  = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [2:0]                req_cmd,
    input  logic [ADDR_SIZE-1:0]      req_addr,
    input  logic [31:0]               req_wdata,
    output logic                      resp_valid,
    output logic [31:0]               resp_rdata,
    output logic                      resp_err,
    output logic [ADDR_SIZE-1:0]      a1,
    inout  wire  [DATA1_BUS_SIZE-1:0] d1,
    inout  wire  [CTR1_BUS_SIZE-1:0]  c1
);

    localparam logic [2:0] C_CMD_NOP     = 3'd0;
    localparam logic [2:0] C_CMD_READ8   = 3'd1;
    localparam logic [2:0] C_CMD_READ16  = 3'd2;
    localparam logic [2:0] C_CMD_READ32  = 3'd3;
    localparam logic [2:0] C_CMD_WRITE8  = 3'd5;
    localparam logic [2:0] C_CMD_WRITE16 = 3'd6;
    localparam logic [2:0] C_CMD_WRITE32 = 3'd7;

    localparam logic [CTR1_BUS_SIZE-1:0] C_C1_NOP      = '0;
    localparam logic [CTR1_BUS_SIZE-1:0] C_C1_RESPONSE = CTR1_BUS_SIZE'(1);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CMD       = 3'd1,
        ST_WDATA2    = 3'd2,
        ST_TURN      = 3'd3,
        ST_WAIT_RESP = 3'd4,
        ST_RDATA2    = 3'd5,
        ST_DONE      = 3'd6
    } state_t;

    state_t                   state_q, state_d;
    logic [2:0]               cmd_q, cmd_d;
    logic [ADDR_SIZE-1:0]     addr_q, addr_d;
    logic [31:0]              wdata_q, wdata_d;
    logic [31:0]              rdata_q, rdata_d;

    logic                      bus_drive;
    logic [DATA1_BUS_SIZE-1:0] d1_out;
    logic [CTR1_BUS_SIZE-1:0]  c1_out;
    logic                      rsp_hit;

`ifdef C1_BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`endif

    // X/Z on c1 compares unknown and is treated as "no response".
    assign rsp_hit = (c1 == C_C1_RESPONSE);

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        bus_drive = 1'b0;
        d1_out    = '0;
        c1_out    = C_C1_NOP;
`ifdef C1_BUS_TIMEOUT_EN
        cnt_d     = cnt_q;
        err_d     = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    rdata_d = '0;
`ifdef C1_BUS_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    if (req_cmd == C_CMD_NOP) begin
                        state_d = ST_DONE;
                    end else begin
                        cmd_d   = req_cmd;
                        addr_d  = req_addr;
                        wdata_d = req_wdata;
                        state_d = ST_CMD;
                    end
                end
            end
            ST_CMD: begin
                bus_drive = 1'b1;
                c1_out    = CTR1_BUS_SIZE'(cmd_q);
                case (cmd_q)
                    C_CMD_WRITE16, C_CMD_WRITE32: d1_out = wdata_q[15:0];
                    C_CMD_WRITE8:                 d1_out = {8'b0, wdata_q[7:0]};
                    default:                      d1_out = '0;
                endcase
                state_d = (cmd_q == C_CMD_WRITE32) ? ST_WDATA2 : ST_TURN;
            end
            ST_WDATA2: begin
                bus_drive = 1'b1;
                c1_out    = C_C1_NOP;
                d1_out    = wdata_q[31:16];
                state_d   = ST_TURN;
            end
            ST_TURN: begin
`ifdef C1_BUS_TIMEOUT_EN
                cnt_d   = '0;
`endif
                state_d = ST_WAIT_RESP;
            end
            ST_WAIT_RESP: begin
                if (rsp_hit) begin
                    case (cmd_q)
                        C_CMD_READ8:  rdata_d = {24'b0, d1[7:0]};
                        C_CMD_READ16: rdata_d = {16'b0, d1[15:0]};
                        C_CMD_READ32: rdata_d = {16'b0, d1[15:0]};
                        default:      rdata_d = '0;
                    endcase
                    state_d = (cmd_q == C_CMD_READ32) ? ST_RDATA2 : ST_DONE;
                end
`ifdef C1_BUS_TIMEOUT_EN
                else if (cnt_q == C_CNT_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_RDATA2: begin
                if (rsp_hit) begin
                    rdata_d = {d1[15:0], rdata_q[15:0]};
                    state_d = ST_DONE;
                end
`ifdef C1_BUS_TIMEOUT_EN
                else if (cnt_q == C_CNT_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cmd_q   <= C_CMD_NOP;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef C1_BUS_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef C1_BUS_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    // Drive enable is decoded from the registered state, so reset releases the bus at once.
    assign d1 = bus_drive ? d1_out : 'z;
    assign c1 = bus_drive ? c1_out : 'z;

    assign a1         = addr_q;
    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_DONE);
    assign resp_rdata = rdata_q;
`ifdef C1_BUS_TIMEOUT_EN
    assign resp_err   = err_q;
`else
    assign resp_err   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_c1_bus_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_c1_bus_master : directed bench for c1_bus_master with a bus responder.  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_c1_bus_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_cmd;
    logic [4:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [4:0]  a1;
    wire  [15:0] d1;
    wire  [3:0]  c1;

    logic        rsp_en;
    logic [15:0] rsp_d1;
    logic [3:0]  rsp_c1;

    int n_checks = 0;
    int n_errors = 0;

    // Released bus lines float high, so "not driven" reads as all ones.
    pullup pu_d1 (d1);
    pullup pu_c1 (c1);
    assign d1 = rsp_en ? rsp_d1 : 'z;
    assign c1 = rsp_en ? rsp_c1 : 'z;

    always #5 clk = ~clk;

    c1_bus_master #(
        .ADDR_SIZE      (5),
        .DATA1_BUS_SIZE (16),
        .CTR1_BUS_SIZE  (4),
        .TIMEOUT_CYCLES (4)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_cmd    (req_cmd),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .a1         (a1),
        .d1         (d1),
        .c1         (c1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Called on a negedge while the DUT is idle; returns on the negedge after acceptance.
    task automatic issue(input logic [2:0] cmd, input logic [4:0] addr, input logic [31:0] wdata);
        req_valid = 1'b1;
        req_cmd   = cmd;
        req_addr  = addr;
        req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic respond(input logic [15:0] data);
        rsp_en = 1'b1;
        rsp_c1 = 4'd1;
        rsp_d1 = data;
    endtask

    task automatic release_bus();
        rsp_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_cmd   = 3'd0;
        req_addr  = 5'd0;
        req_wdata = 32'd0;
        rsp_en    = 1'b0;
        rsp_d1    = 16'd0;
        rsp_c1    = 4'd0;
        repeat (2) step();
        check("rst_ready", req_ready, 1);
        check("rst_valid", resp_valid, 0);
        check("rst_rdata", resp_rdata, 32'h0);
        check("rst_err",   resp_err, 0);
        check("rst_a1",    a1, 5'd0);
        check("rst_d1",    d1, 16'hFFFF);
        check("rst_c1",    c1, 4'hF);
        reset = 1'b0;
        step();

        // READ8 addr 3, reply on first wait cycle
        issue(3'd1, 5'd3, 32'h0);
        check("r8_cmd_c1",    c1, 4'd1);
        check("r8_cmd_d1",    d1, 16'h0000);
        check("r8_cmd_a1",    a1, 5'd3);
        check("r8_cmd_ready", req_ready, 0);
        step();
        check("r8_turn_d1",    d1, 16'hFFFF);
        check("r8_turn_c1",    c1, 4'hF);
        check("r8_turn_valid", resp_valid, 0);
        step();
        check("r8_wait_d1",    d1, 16'hFFFF);
        check("r8_wait_valid", resp_valid, 0);
        respond(16'h00A5);
        step();
        check("r8_done_valid", resp_valid, 1);
        check("r8_done_rdata", resp_rdata, 32'h000000A5);
        check("r8_done_err",   resp_err, 0);
        release_bus();
        step();
        check("r8_idle_valid", resp_valid, 0);
        check("r8_idle_ready", req_ready, 1);
        check("r8_idle_a1",    a1, 5'd3);

        // WRITE32 addr 7
        issue(3'd7, 5'd7, 32'hDEADBEEF);
        check("w32_cmd_c1", c1, 4'd7);
        check("w32_cmd_d1", d1, 16'hBEEF);
        check("w32_cmd_a1", a1, 5'd7);
        step();
        check("w32_d2_c1", c1, 4'd0);
        check("w32_d2_d1", d1, 16'hDEAD);
        step();
        check("w32_turn_d1", d1, 16'hFFFF);
        check("w32_turn_c1", c1, 4'hF);
        step();
        check("w32_wait_valid", resp_valid, 0);
        respond(16'h5555);
        step();
        check("w32_done_valid", resp_valid, 1);
        check("w32_done_rdata", resp_rdata, 32'h0);
        release_bus();
        step();
        check("w32_idle_valid", resp_valid, 0);

        // WRITE8 zero-extends the low byte onto d1
        issue(3'd5, 5'd1, 32'h12345678);
        check("w8_cmd_c1", c1, 4'd5);
        check("w8_cmd_d1", d1, 16'h0078);
        step();
        step();
        respond(16'h0000);
        step();
        check("w8_done_valid", resp_valid, 1);
        release_bus();
        step();

        // READ32 with two idle cycles between beats
        issue(3'd3, 5'd5, 32'h0);
        check("r32_cmd_c1", c1, 4'd3);
        step();
        step();
        respond(16'h1234);
        step();
        check("r32_b1_valid", resp_valid, 0);
        release_bus();
        step();
        check("r32_gap1_valid", resp_valid, 0);
        step();
        check("r32_gap2_valid", resp_valid, 0);
        respond(16'hABCD);
        step();
        check("r32_done_valid", resp_valid, 1);
        check("r32_done_rdata", resp_rdata, 32'hABCD1234);
        release_bus();
        step();
        check("r32_single_pulse", resp_valid, 0);

        // NOP: straight to DONE, no bus activity
        issue(3'd0, 5'd9, 32'hFFFFFFFF);
        check("nop_valid", resp_valid, 1);
        check("nop_rdata", resp_rdata, 32'h0);
        check("nop_d1",    d1, 16'hFFFF);
        check("nop_c1",    c1, 4'hF);
        check("nop_ready", req_ready, 0);
        step();
        check("nop_ready_back", req_ready, 1);
        check("nop_valid_low",  resp_valid, 0);

        // Reset during WAIT_RESP of READ16
        issue(3'd2, 5'd2, 32'h0);
        step();
        step();
        reset = 1'b1;
        #1;
        check("arst_d1",    d1, 16'hFFFF);
        check("arst_c1",    c1, 4'hF);
        check("arst_ready", req_ready, 1);
        check("arst_valid", resp_valid, 0);
        step();
        reset = 1'b0;
        step();
        check("arst_post_valid", resp_valid, 0);
        step();
        check("arst_post_valid2", resp_valid, 0);

        issue(3'd2, 5'd31, 32'h0);
        check("r16_cmd_c1", c1, 4'd2);
        step();
        step();
        respond(16'hBEEF);
        step();
        check("r16_done_valid", resp_valid, 1);
        check("r16_done_rdata", resp_rdata, 32'h0000BEEF);
        check("r16_done_a1",    a1, 5'd31);
        release_bus();
        step();

`ifdef C1_BUS_TIMEOUT_EN
        // No response: error after 4 wait cycles
        issue(3'd1, 5'd4, 32'h0);
        step();
        repeat (4) begin
            step();
            check("to_wait_valid", resp_valid, 0);
        end
        step();
        check("to_done_valid", resp_valid, 1);
        check("to_done_err",   resp_err, 1);
        check("to_done_rdata", resp_rdata, 32'h0);
        step();

        // Response on the 4th wait cycle wins
        issue(3'd1, 5'd4, 32'h0);
        step();
        repeat (3) step();
        step();
        check("tw_wait4_valid", resp_valid, 0);
        respond(16'h0077);
        step();
        check("tw_done_valid", resp_valid, 1);
        check("tw_done_err",   resp_err, 0);
        check("tw_done_rdata", resp_rdata, 32'h00000077);
        release_bus();
        step();
`else
        // Without the watchdog the master waits indefinitely
        issue(3'd1, 5'd4, 32'h0);
        step();
        repeat (20) begin
            step();
            check("nw_wait_valid", resp_valid, 0);
        end
        respond(16'h003C);
        step();
        check("nw_done_valid", resp_valid, 1);
        check("nw_done_err",   resp_err, 0);
        check("nw_done_rdata", resp_rdata, 32'h0000003C);
        release_bus();
        step();
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
